// File: rtl/bcd_calendar_sequencer.sv
// BCD calendar date register advanced one day per accepted tick via an
// IDLE -> EVAL -> UPDATE sequence, with validated synchronous date preset.
//
// Ports:
//   clock, reset_n         : clock, async active-low reset
//   tick                   : advance one day (accepted only in IDLE)
//   load, ld_year/month/day: preset request with BCD date
//   year, month, day, leap : current BCD date and leap flag
//   busy                   : sequencer not in IDLE
//   done, wrap             : new date visible / 9999-12-31 rolled to 0000
//   tick_drop, load_err    : tick not accepted / load rejected
module bcd_calendar_sequencer #(
   parameter logic [15:0] RESET_YEAR  = 16'h2000,
   parameter logic [7:0]  RESET_MONTH = 8'h01,
   parameter logic [7:0]  RESET_DAY   = 8'h01
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        tick,
   input  logic        load,
   input  logic [15:0] ld_year,
   input  logic [7:0]  ld_month,
   input  logic [7:0]  ld_day,
   output logic [15:0] year,
   output logic [7:0]  month,
   output logic [7:0]  day,
   output logic        leap,
   output logic        busy,
   output logic        done,
   output logic        wrap,
   output logic        tick_drop,
   output logic        load_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Two BCD digits T:O are divisible by 4 iff (2*T + O) is.
   function automatic logic is_leap(input logic [15:0] y);
      logic [4:0] lo;
      logic [4:0] hi;
      logic       lo_zero;
      lo      = {y[7:4], 1'b0} + {1'b0, y[3:0]};
      hi      = {y[15:12], 1'b0} + {1'b0, y[11:8]};
      lo_zero = (y[7:0] == 8'h00);
      return ((lo[1:0] == 2'b00) && !lo_zero) ||
             (lo_zero && (hi[1:0] == 2'b00));
   endfunction

   function automatic logic [7:0] dim(input logic [7:0] m,
                                      input logic       lp);
      logic [7:0] r;
      case (m)
         8'h02:                      r = lp ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
         default:                    r = 8'h31;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'h9) r = {v[7:4] + 4'h1, 4'h0};
      else                r = {v[7:4], v[3:0] + 4'h1};
      return r;
   endfunction

   function automatic logic [15:0] inc_year(input logic [15:0] y);
      logic [15:0] r;
      logic        c;
      r = y;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'h9) begin
               r[i*4 +: 4] = 4'h0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'h1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] year_q, year_d;
   logic [7:0]  month_q, month_d;
   logic [7:0]  day_q, day_d;
   logic        leap_q, leap_d;
   logic        last_day_q, last_day_d;
   logic        last_month_q, last_month_d;
   logic        last_year_q, last_year_d;
   logic        done_q, done_d;
   logic        wrap_q, wrap_d;
   logic        tick_drop_q, tick_drop_d;
   logic        load_err_q, load_err_d;

   logic [31:0] ld_all;
   logic        ld_digits_ok;
   logic        ld_leap;
   logic        ld_ok;

   assign ld_all = {ld_year, ld_month, ld_day};

   always_comb begin
      ld_digits_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (ld_all[i*4 +: 4] > 4'h9) ld_digits_ok = 1'b0;
      end
   end

   assign ld_leap = is_leap(ld_year);
   // Nibbles are checked to be decimal, so BCD compares order like binary.
   assign ld_ok   = ld_digits_ok &&
                    (ld_month >= 8'h01) && (ld_month <= 8'h12) &&
                    (ld_day >= 8'h01) &&
                    (ld_day <= dim(ld_month, ld_leap));

   always_comb begin
      state_d      = state_q;
      year_d       = year_q;
      month_d      = month_q;
      day_d        = day_q;
      leap_d       = leap_q;
      last_day_d   = last_day_q;
      last_month_d = last_month_q;
      last_year_d  = last_year_q;
      done_d       = 1'b0;
      wrap_d       = 1'b0;
      tick_drop_d  = 1'b0;
      load_err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load) begin
               tick_drop_d = tick;
               if (ld_ok) begin
                  year_d  = ld_year;
                  month_d = ld_month;
                  day_d   = ld_day;
                  leap_d  = ld_leap;
                  done_d  = 1'b1;
               end else begin
                  load_err_d = 1'b1;
               end
            end else if (tick) begin
               state_d = EVAL;
            end
         end
         EVAL: begin
            tick_drop_d  = tick;
            load_err_d   = load;
            last_day_d   = (day_q == dim(month_q, leap_q));
            last_month_d = (month_q == 8'h12);
            last_year_d  = (year_q == 16'h9999);
            state_d      = UPDATE;
         end
         UPDATE: begin
            tick_drop_d = tick;
            load_err_d  = load;
            if (!last_day_q) begin
               day_d = bcd_inc2(day_q);
            end else if (!last_month_q) begin
               day_d   = 8'h01;
               month_d = bcd_inc2(month_q);
            end else begin
               day_d   = 8'h01;
               month_d = 8'h01;
               year_d  = last_year_q ? 16'h0000 : inc_year(year_q);
               wrap_d  = last_year_q;
            end
            leap_d  = is_leap(year_d);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         year_q       <= RESET_YEAR;
         month_q      <= RESET_MONTH;
         day_q        <= RESET_DAY;
         leap_q       <= is_leap(RESET_YEAR);
         last_day_q   <= 1'b0;
         last_month_q <= 1'b0;
         last_year_q  <= 1'b0;
         done_q       <= 1'b0;
         wrap_q       <= 1'b0;
         tick_drop_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         year_q       <= year_d;
         month_q      <= month_d;
         day_q        <= day_d;
         leap_q       <= leap_d;
         last_day_q   <= last_day_d;
         last_month_q <= last_month_d;
         last_year_q  <= last_year_d;
         done_q       <= done_d;
         wrap_q       <= wrap_d;
         tick_drop_q  <= tick_drop_d;
         load_err_q   <= load_err_d;
      end
   end

   assign year      = year_q;
   assign month     = month_q;
   assign day       = day_q;
   assign leap      = leap_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign wrap      = wrap_q;
   assign tick_drop = tick_drop_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_calendar_sequencer.sv
// Scoreboarded random/directed bench for bcd_calendar_sequencer.
// Reference model keeps the date as integers with Gregorian arithmetic.
module tb_bcd_calendar_sequencer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick = 1'b0;
   logic        load = 1'b0;
   logic [15:0] ld_year = '0;
   logic [7:0]  ld_month = '0;
   logic [7:0]  ld_day = '0;
   logic [15:0] year;
   logic [7:0]  month;
   logic [7:0]  day;
   logic        leap;
   logic        busy;
   logic        done;
   logic        wrap;
   logic        tick_drop;
   logic        load_err;

   bcd_calendar_sequencer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .tick      (tick),
      .load      (load),
      .ld_year   (ld_year),
      .ld_month  (ld_month),
      .ld_day    (ld_day),
      .year      (year),
      .month     (month),
      .day       (day),
      .leap      (leap),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap),
      .tick_drop (tick_drop),
      .load_err  (load_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  pulses;
      logic [15:0] y;
      logic [7:0]  m;
      logic [7:0]  d;
      logic        lp;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   my, mm, md;
   int   busy_cnt;

   function automatic bit leap_of(input int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int dim_of(input int m, input int y);
      int r;
      if (m == 2)                                   r = leap_of(y) ? 29 : 28;
      else if (m == 4 || m == 6 || m == 9 || m == 11) r = 30;
      else                                          r = 31;
      return r;
   endfunction

   function automatic logic [15:0] bcd4(input int v);
      logic [15:0] r;
      int          t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int val(input logic [15:0] b);
      return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
   endfunction

   function automatic bit digits_ok(input logic [31:0] v);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict the response after this edge.
   task automatic step(input logic t, input logic l, input logic [15:0] ly,
                       input logic [7:0] lm, input logic [7:0] ldd);
      exp_t e;
      bit   dn, wr, dr, er;
      int   iy, im, id;
      tick = t; load = l;
      ld_year = ly; ld_month = lm; ld_day = ldd;
      dn = 0; wr = 0; dr = 0; er = 0;
      if (busy_cnt > 0) begin
         dr = t; er = l;
         busy_cnt--;
         if (busy_cnt == 0) begin
            dn = 1;
            md++;
            if (md > dim_of(mm, my)) begin
               md = 1; mm++;
               if (mm > 12) begin
                  mm = 1; my++;
                  if (my > 9999) begin my = 0; wr = 1; end
               end
            end
         end
      end else if (l) begin
         dr = t;
         iy = val(ly); im = val({8'h00, lm}); id = val({8'h00, ldd});
         if (digits_ok({ly, lm, ldd}) && im >= 1 && im <= 12 &&
             id >= 1 && id <= dim_of(im, iy)) begin
            my = iy; mm = im; md = id; dn = 1;
         end else begin
            er = 1;
         end
      end else if (t) begin
         busy_cnt = 2;
      end
      if (dn || wr || dr || er) begin
         e.pulses = {dn, wr, dr, er};
         e.y = bcd4(my); e.m = bcd2(mm); e.d = bcd2(md);
         e.lp = leap_of(my);
         q.push_back(e);
      end
      @(posedge clock);
      #1;
      tick = 0; load = 0;
      chk("busy", 64'(busy), 64'(busy_cnt > 0));
      chk("date", {23'd0, year, month, day, leap},
          {23'd0, bcd4(my), bcd2(mm), bcd2(md), leap_of(my)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 16'h0, 8'h0, 8'h0);
   endtask

   task automatic do_load(input int y, input int m, input int d);
      step(0, 1, bcd4(y), bcd2(m), bcd2(d));
   endtask

   task automatic do_tick();
      step(1, 0, 16'h0, 8'h0, 8'h0);
      idle(2);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (reset_n && (done || wrap || tick_drop || load_err)) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected pulse: got d/w/td/le=%b%b%b%b none expected",
                     done, wrap, tick_drop, load_err);
         end else begin
            e = q.pop_front();
            if ({done, wrap, tick_drop, load_err} !== e.pulses ||
                year !== e.y || month !== e.m || day !== e.d ||
                leap !== e.lp) begin
               miscompares++;
               $display("FAIL event: got %b %h-%h-%h lp=%b expected %b %h-%h-%h lp=%b",
                        {done, wrap, tick_drop, load_err}, year, month, day,
                        leap, e.pulses, e.y, e.m, e.d, e.lp);
            end
         end
      end
   end

   initial begin
      logic [15:0] ry;
      logic [7:0]  rm, rd;
      my = 2000; mm = 1; md = 1; busy_cnt = 0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      chk("reset_date", {year, month, day}, {16'h2000, 8'h01, 8'h01});
      chk("reset_flags", {leap, busy, done, wrap, tick_drop, load_err},
          6'b100000);
      idle(2);

      do_load(2024, 2, 28); do_tick(); do_tick();
      do_load(2023, 2, 28); do_tick();
      do_load(1900, 2, 28); do_tick();
      do_load(2000, 2, 28); do_tick();
      do_load(1999, 9, 30); do_tick();
      do_load(9999, 12, 31); do_tick();
      do_load(2023, 2, 29);
      do_load(2024, 13, 1);
      step(0, 1, 16'h20A4, 8'h05, 8'h05);
      step(1, 0, 16'h0, 8'h0, 8'h0);
      step(1, 0, 16'h0, 8'h0, 8'h0);
      idle(2);
      step(1, 0, 16'h0, 8'h0, 8'h0);
      do_load(2010, 6, 15);
      idle(2);
      step(1, 1, bcd4(2012), bcd2(7), bcd2(31));
      idle(1);
      do_load(999, 12, 31); do_tick();

      for (int i = 0; i < 400; i++) begin
         ry = bcd4($urandom_range(0, 9999));
         rm = bcd2($urandom_range(0, 13));
         rd = bcd2($urandom_range(0, 32));
         if ($urandom_range(0, 4) == 0) begin
            rd = bcd2($urandom_range(27, 31));
            rm = 8'h12;
            if ($urandom_range(0, 1) == 1) ry = 16'h9999;
         end
         if ($urandom_range(0, 15) == 0) ry[3:0] = 4'($urandom_range(10, 15));
         step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
              ry, rm, rd);
      end
      idle(3);

      step(1, 0, 16'h0, 8'h0, 8'h0);
      reset_n = 1'b0;
      #1;
      my = 2000; mm = 1; md = 1; busy_cnt = 0;
      chk("async_reset_date", {year, month, day}, {16'h2000, 8'h01, 8'h01});
      chk("async_reset_flags", {leap, busy, done, wrap, tick_drop, load_err},
          6'b100000);
      #2;
      reset_n = 1'b1;
      idle(5);

      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
